// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
// Holds the fetch PC, issues word reads to instruction memory, buffers returned
// words in a small prefetch FIFO and presents {instr, instr_pc} to decode.
// Redirects flush the FIFO and mark every outstanding read as stale.
//
// Handshake semantics (both channels): a transfer happens on a rising edge where
// valid && ready are both high. The producer never lowers valid or changes its
// payload while valid && !ready, except that a redirect may retarget the request
// address. The memory response channel has no ready: responses return in
// request order and the credit rule below guarantees room for each of them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  dbg_state
);

    // Pointer width and counter width (counters must hold 0..FIFO_DEPTH).
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [CW-1:0]   r_in_flight;
    logic [CW-1:0]   r_stale;

    // Prefetch FIFO: data and the PC each word was fetched from.
    logic [31:0]     r_fifo_instr [FIFO_DEPTH];
    logic [31:0]     r_fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]   r_fifo_rd;
    logic [PW-1:0]   r_fifo_wr;
    logic [CW-1:0]   r_fifo_count;

    // In-order tag queue: PC of each outstanding read, popped by its response.
    logic [31:0]     r_tag_q [FIFO_DEPTH];
    logic [PW-1:0]   r_tag_rd;
    logic [PW-1:0]   r_tag_wr;

    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_push;
    logic            w_pop;
    logic [CW:0]     w_credit_used;
    logic [CW-1:0]   w_in_flight_nxt;
    logic [31:0]     w_tag_head;

    // Outstanding reads plus buffered words may never exceed the FIFO size, so
    // every response is guaranteed a slot. Derived from registers only.
    assign w_credit_used  = {1'b0, r_in_flight} + {1'b0, r_fifo_count};
    assign imem_req_valid = (r_state == S_FETCH) && (w_credit_used < CREDIT_MAX);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign w_rsp_take = imem_rsp_valid && (r_in_flight != '0);
    // Only live responses enter the FIFO; a redirect in the same cycle discards it.
    assign w_push     = w_rsp_take && (r_stale == '0) && !redirect;
    assign w_pop      = instr_valid && instr_ready;

    assign w_in_flight_nxt = r_in_flight + CW'(w_req_fire) - CW'(w_rsp_take);
    assign w_tag_head      = r_tag_q[r_tag_rd];

    assign instr_valid = (r_fifo_count != '0);
    assign instr       = instr_valid ? r_fifo_instr[r_fifo_rd] : 32'h0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_fifo_rd]    : 32'h0;
    assign dbg_state   = r_state;

    // Control FSM, fetch PC, outstanding-read and stale-read counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_in_flight <= '0;
            r_stale     <= '0;
        end else begin
            r_in_flight <= w_in_flight_nxt;
            if (redirect) begin
                // Everything still outstanding after this cycle belongs to the old path.
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                r_stale    <= w_in_flight_nxt;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_take && (r_stale != '0)) begin
                    r_stale <= r_stale - CW'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (redirect && (w_in_flight_nxt != '0)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        // Stay while stale reads remain; leave if the last one
                        // returned in this very cycle, so DRAIN can never stall.
                        r_state <= (w_in_flight_nxt != '0) ? S_DRAIN : S_FETCH;
                    end else if ((r_stale == '0) ||
                                 (w_rsp_take && (r_stale == CW'(1)))) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO outright.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fifo_rd    <= '0;
            r_fifo_wr    <= '0;
            r_fifo_count <= '0;
        end else if (redirect) begin
            r_fifo_rd    <= '0;
            r_fifo_wr    <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= r_fifo_wr + PW'(1);
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + PW'(1);
            end
            r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage: word and its PC taken from the head of the tag queue.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
            r_fifo_pc[r_fifo_wr]    <= w_tag_head;
        end
    end

    // Tag queue pointers; not flushed by redirect because stale reads still return.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag_rd <= '0;
            r_tag_wr <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag_wr <= r_tag_wr + PW'(1);
            end
            if (w_rsp_take) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
        end
    end

    // Tag storage: remember the address of every accepted request.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag_q[r_tag_wr] <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for streaming and back-pressure, plus
// hand-written sequences for redirect, address wrap and reset mid-flight.
module tb_fetch_unit;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic        rdy;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_instr_valid;
    logic [31:0] exp_instr_pc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // memory model and scoreboard
  logic        mem_en;
  logic [31:0] mem_q[$];
  int          mem_cyc_q[$];
  logic        sb_on;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step();
    logic [31:0] e;
    if (mem_en) begin
      if (mem_q.size() > 0 && mem_cyc_q[0] < cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(mem_q[0]);
        void'(mem_q.pop_front());
        void'(mem_cyc_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
    if (sb_on) instr_ready = (exp_q.size() != 0);
    if (sb_on && instr_valid && instr_ready) begin
      e = exp_q.pop_front();
      chk("sb_pc", instr_pc, e);
      chk("sb_instr", instr, mdata(e));
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
      mem_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    mem_q.delete();
    mem_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain timeout actual_left=%0d expected_left=0", name, exp_q.size());
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    chk({name, "_req_valid"}, 32'(imem_req_valid), 32'(v.exp_req_valid));
    chk({name, "_req_addr"}, imem_req_addr, v.exp_req_addr);
    chk({name, "_instr_valid"}, 32'(instr_valid), 32'(v.exp_instr_valid));
    chk({name, "_instr_pc"}, instr_pc, v.exp_instr_pc);
    chk({name, "_instr"}, instr, v.exp_instr_valid ? mdata(v.exp_instr_pc) : 32'h0);
    instr_ready = v.rdy;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[8];
    vec_t t2[9];

    // streaming, 1-cycle memory, decoder always ready
    t1[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    t1[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    t1[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    t1[3] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
    t1[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    t1[5] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
    t1[6] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
    t1[7] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

    // decoder stalled: credits cap requests at two until a pop
    t2[0] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
    t2[1] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    t2[2] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    t2[3] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    t2[4] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    t2[5] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
    t2[6] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4};
    t2[7] = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h4};
    t2[8] = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h4};

    mem_en = 1'b1;
    sb_on  = 1'b0;

    // table 1
    do_reset();
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) run_vec("stream", t1[i]);

    // table 2
    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) run_vec("stall", t2[i]);

    // redirect with two reads outstanding
    do_reset();
    sb_on = 1'b1;
    mem_en = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    step(); step(); step();
    chk("rd2_req_valid_full", 32'(imem_req_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    chk("rd2_state_drain_a", 32'(dbg_state), 32'(ST_DRAIN));
    mem_en = 1'b1;
    step();
    chk("rd2_state_drain_b", 32'(dbg_state), 32'(ST_DRAIN));
    step();
    chk("rd2_state_fetch", 32'(dbg_state), 32'(ST_FETCH));
    chk("rd2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rd2_req_addr", imem_req_addr, 32'h100);
    drain("rd2", 20);

    // redirect in the same cycle as a response, unaligned target
    do_reset();
    sb_on = 1'b1;
    mem_en = 1'b1;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    step(); step();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    chk("rdrsp_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    chk("rdrsp_instr_valid", 32'(instr_valid), 32'd0);
    step();
    chk("rdrsp_state_fetch", 32'(dbg_state), 32'(ST_FETCH));
    chk("rdrsp_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rdrsp_req_addr", imem_req_addr, 32'h200);
    drain("rdrsp", 20);

    // address wrap at the top of the address space
    do_reset();
    sb_on = 1'b1;
    mem_en = 1'b1;
    imem_req_ready = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    step();
    chk("wrap_req_valid_hold", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr_hold", imem_req_addr, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    chk("wrap_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_state", 32'(dbg_state), 32'(ST_FETCH));
    imem_req_ready = 1'b1;
    step();
    chk("wrap_req_addr_zero", imem_req_addr, 32'h0000_0000);
    drain("wrap", 20);

    // reset with two reads outstanding, their responses arrive after release
    do_reset();
    sb_on = 1'b0;
    mem_en = 1'b0;
    imem_req_ready = 1'b1;
    step(); step(); step();
    chk("rst_pre_req_valid", 32'(imem_req_valid), 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    mem_q.delete();
    mem_cyc_q.delete();
    sb_on = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    step();
    chk("rst_ghost_a", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_0BAD;
    step();
    chk("rst_ghost_b", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    mem_en = 1'b1;
    step();
    drain("rst", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
